dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
- Initiator-side controller that drives one DSP48A1 slice as a dot-product engine.
- Accepts a stream of 18-bit operand pairs over a valid/ready handshake and drives the slice's A, B, OPMODE, clock-enable and reset pins.
- Tracks the slice's pipeline latency, captures P when the last product of a vector has been accumulated, and returns the 48-bit sum over a valid/ready result interface.
- Sits between a sample source (a FIR or matrix datapath) and the DSP48A1 instance, which is configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".

Parameters:
- VEC_LEN, 8, number of operand pairs per dot product (legal range 2..65535).
- PIPE_LAT, 3, cycles from operand acceptance on A/B to the product being registered in P (legal range 2 or more; 3 matches the slice configuration above).
- CNT_W, 16, width of the element counter (must satisfy 2^CNT_W >= VEC_LEN).

Ports:
- CLK  in  1  single clock for the sequencer and the slice.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  18  operand A (unsigned).
- in_b  in  18  operand B (unsigned).
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  48  dot-product result.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_ce  out  1  to slice CEA/CEB/CEM/CEP/CEOPMODE.
- dsp_rst  out  1  to all slice RSTx pins.
- dsp_p  in  48  from slice P.

Behaviour:
- Reset is synchronous, active-high on RST, clocked by CLK.
- Reset values: in_ready=0 during reset, res_valid=0, res_data=0, state=ACCUM, element counter=0, all pipeline tags cleared. dsp_rst=RST (combinational pass-through), so the slice clears in the same cycle.
- dsp_ce=1 whenever RST=0. Slice CARRYIN and CECARRYIN are tied 0 at the instance.
- Accept (fire) = in_valid && in_ready. On fire: dsp_a=in_a and dsp_b=in_b in the same cycle (combinational). When not firing, dsp_a and dsp_b are 0.
- Tag pipeline: a PIPE_LAT-deep shift register carrying {valid, first, last} for each cycle.
  - first = counter==0.
  - last = counter==VEC_LEN-1.
  - Counter increments on fire and wraps to 0 after last.
- dsp_opmode is driven from tag stage PIPE_LAT-2, i.e. one cycle after acceptance for PIPE_LAT=3. This aligns with the slice's OPMODE register:
  - valid && first: 8'h01 (X=M, Z=0; restarts the accumulation).
  - valid && !first: 8'h09 (X=M, Z=P).
  - bubble (tag invalid): 8'h08 (X=0, Z=P; hold).
  - Bits 7:4 are always 0: add, pre-adder bypassed, carry-in 0.
- Arithmetic: unsigned 18x18 gives a 36-bit product; the accumulation is 48-bit modulo 2^48 with no saturation.
- FSM states:
  - ACCUM: in_ready=1. On fire of the last element, go to DRAIN and load the drain counter with PIPE_LAT.
  - DRAIN: in_ready=0. Decrement the drain counter each cycle. When it reaches 0 (cycle t_last+PIPE_LAT), load res_data from dsp_p and go to HOLD.
  - HOLD: res_valid=1 and res_data is stable. On res_valid && res_ready, go to ACCUM and set res_valid=0 next cycle. in_ready stays 0 through the handshake cycle.
- Latency: res_valid rises at cycle t_last+PIPE_LAT+1.
- Minimum period per vector: VEC_LEN + PIPE_LAT + 2 cycles.
- Input gaps (in_valid low) inside a vector insert hold bubbles; the result is unchanged.
- RST asserted mid-vector or in HOLD: the partial sum and any pending result are discarded, the counter returns to 0, and the next accepted pair is treated as first.
- res_ready asserted outside HOLD is ignored.

Optional Feature:
- Macro: DSP_MAC_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output port perf_vec_cnt (out, 32), counting completed result handshakes.
  - Resets to 0 and wraps at 2^32.
  - Adds output port perf_stall_cnt (out, 32), counting cycles where in_valid=1 and in_ready=0; it saturates at 2^32-1.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Bench setup: sequencer plus DSP48A1 instance with the configuration above, PIPE_LAT=3.
- VEC_LEN=4, pairs (1,5),(2,6),(3,7),(4,8) back-to-back -> res_data=70, res_valid high at t_last+4, in_ready low from t_last+1.
- Same vector with in_valid low for 2 cycles between each pair, followed by a second vector (10,10)x4 -> results 70 then 400; the first result is not leaked into the second.
- VEC_LEN=8, all pairs (262143,262143) -> res_data=549751619592.
- res_ready held low 10 cycles in HOLD -> res_valid stays 1, res_data stable, in_ready 0, and with the macro defined perf_stall_cnt increments each cycle in_valid=1. Raising res_ready -> one handshake, in_ready=1 two cycles later.
- RST pulsed for 1 cycle after 2 of 4 pairs -> res_valid=0, dsp_rst=1 that cycle. A fresh vector (1,1)x4 -> res_data=4.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: runs one DSP48A1 slice as a dot-product engine.
// It accepts 18-bit operand pairs over a valid/ready handshake and drives
// the slice's A/B/OPMODE/CE/RST pins. It tracks the slice pipeline, captures
// P after the last product of a vector, and returns the 48-bit sum over a
// valid/ready result interface.
//
// Expected slice configuration: A0REG=0 A1REG=1 B0REG=0 B1REG=1 MREG=1
// PREG=1 OPMODEREG=1, CARRYIN/CECARRYIN tied 0 at the instance.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_ready   operand pair handshake, in_a/in_b operands (unsigned)
//   res_valid/res_ready result handshake, res_data 48-bit dot product
//   dsp_a/dsp_b         slice A/B (driven only on an accepted pair, else 0)
//   dsp_opmode          slice OPMODE (slice registers it internally)
//   dsp_ce, dsp_rst     slice clock enables / resets
//   dsp_p               slice P output
//
// Optional feature macro DSP_MAC_SEQ_PERF_CNT_EN adds perf_vec_cnt
// (completed result handshakes, wrapping) and perf_stall_cnt (cycles with
// in_valid=1 and in_ready=0, saturating).

module dsp_mac_sequencer #(
    parameter int unsigned VEC_LEN  = 8,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_data,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    output logic        dsp_rst,
    input  logic [47:0] dsp_p
`ifdef DSP_MAC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_vec_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned       DRN_W    = $clog2(PIPE_LAT + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic [DRN_W-1:0]  DRN_INIT = DRN_W'(PIPE_LAT);

    // OPMODE encodings: X=M/Z=0 restarts, X=M/Z=P accumulates, X=0/Z=P holds
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic             in_ready_q;
    logic [CNT_W-1:0] elem_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             fire;
    logic             is_first;
    logic             is_last;
    logic [1:0]       op_tag;     // {valid, first} aligned to the OPMODE register

    // in_ready is forced low while reset is asserted so nothing fires then
    assign in_ready = in_ready_q & ~RST;
    assign fire     = in_valid & in_ready;
    assign is_first = (elem_cnt == '0);
    assign is_last  = (elem_cnt == LAST_IDX);

    // Slice pin drive; A/B go straight in because A0REG/B0REG are bypassed
    assign dsp_a   = fire ? in_a : 18'd0;
    assign dsp_b   = fire ? in_b : 18'd0;
    assign dsp_rst = RST;
    assign dsp_ce  = ~RST;

    // Tag delay line: OPMODE is presented PIPE_LAT-2 cycles after acceptance.
    // Only {valid, first} feed OPMODE, so only those bits are carried.
    generate
        if (PIPE_LAT == 2) begin : g_tag_direct
            assign op_tag = {fire, is_first};
        end else begin : g_tag_pipe
            logic [1:0] tag_q [PIPE_LAT-2];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int i = 0; i < int'(PIPE_LAT) - 2; i++) begin
                        tag_q[i] <= 2'b00;
                    end
                end else begin
                    tag_q[0] <= {fire, is_first};
                    for (int i = 1; i < int'(PIPE_LAT) - 2; i++) begin
                        tag_q[i] <= tag_q[i-1];
                    end
                end
            end

            assign op_tag = tag_q[PIPE_LAT-3];
        end
    endgenerate

    // OPMODE select from the aligned tag
    always_comb begin
        dsp_opmode = OP_HOLD;
        if (op_tag[1]) begin
            dsp_opmode = op_tag[0] ? OP_FIRST : OP_ACC;
        end
    end

    // Sequencer FSM: accumulate, drain the slice pipeline, hold the result.
    // in_ready is registered, so it returns one cycle after re-entering ACCUM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ACCUM;
            in_ready_q <= 1'b0;
            elem_cnt   <= '0;
            drain_cnt  <= '0;
            res_valid  <= 1'b0;
            res_data   <= 48'd0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (fire) begin
                        if (is_last) begin
                            elem_cnt   <= '0;
                            in_ready_q <= 1'b0;
                            drain_cnt  <= DRN_INIT;
                            state      <= DRAIN;
                        end else begin
                            elem_cnt <= elem_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    in_ready_q <= 1'b0;
                    drain_cnt  <= drain_cnt - DRN_W'(1);
                    // Counter hits 0 on this edge: P now holds the final sum
                    if (drain_cnt == DRN_W'(1)) begin
                        res_data  <= dsp_p;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    in_ready_q <= 1'b0;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

`ifdef DSP_MAC_SEQ_PERF_CNT_EN
    // Performance counters: wrapping handshake count, saturating stall count
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_vec_cnt   <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (res_valid && res_ready) begin
                perf_vec_cnt <= perf_vec_cnt + 32'd1;
            end
            if (in_valid && !in_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two sequencers (VEC_LEN=4 and VEC_LEN=8,
// PIPE_LAT=3), each driving a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE
// registers, X/Z muxes, 48-bit adder).

module tb_dsp_mac_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic [1:0]  res_valid;
    logic        res_ready;
    logic [47:0] res_data   [2];
    logic [17:0] dsp_a      [2];
    logic [17:0] dsp_b      [2];
    logic [7:0]  dsp_opmode [2];
    logic [1:0]  dsp_ce;
    logic [1:0]  dsp_rst;
    logic [47:0] dsp_p      [2];
`ifdef DSP_MAC_SEQ_PERF_CNT_EN
    logic [31:0] perf_vec_cnt   [2];
    logic [31:0] perf_stall_cnt [2];
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [17:0] va [8];
    logic [17:0] vb [8];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            dsp_mac_sequencer #(
                .VEC_LEN  ((g == 0) ? 4 : 8),
                .PIPE_LAT (3),
                .CNT_W    (16)
            ) u_dut (
                .CLK        (CLK),
                .RST        (RST),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .in_a       (in_a),
                .in_b       (in_b),
                .res_valid  (res_valid[g]),
                .res_ready  (res_ready),
                .res_data   (res_data[g]),
                .dsp_a      (dsp_a[g]),
                .dsp_b      (dsp_b[g]),
                .dsp_opmode (dsp_opmode[g]),
                .dsp_ce     (dsp_ce[g]),
                .dsp_rst    (dsp_rst[g]),
                .dsp_p      (dsp_p[g])
`ifdef DSP_MAC_SEQ_PERF_CNT_EN
                ,
                .perf_vec_cnt   (perf_vec_cnt[g]),
                .perf_stall_cnt (perf_stall_cnt[g])
`endif
            );

            // Behavioural DSP48A1 slice
            logic [17:0] a1;
            logic [17:0] b1;
            logic [35:0] m;
            logic [7:0]  op_r;
            logic [47:0] p;
            logic [47:0] xm;
            logic [47:0] zm;

            always_comb begin
                xm = (op_r[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
                zm = (op_r[3:2] == 2'b10) ? p : 48'd0;
            end

            always @(posedge CLK) begin
                if (dsp_rst[g]) begin
                    a1 <= 18'd0; b1 <= 18'd0; m <= 36'd0; op_r <= 8'd0; p <= 48'd0;
                end else if (dsp_ce[g]) begin
                    a1   <= dsp_a[g];
                    b1   <= dsp_b[g];
                    m    <= 36'(a1) * 36'(b1);
                    op_r <= dsp_opmode[g];
                    p    <= xm + zm;
                end
            end

            assign dsp_p[g] = p;
        end
    endgenerate

    // Present one pair and wait (bounded) until it is accepted
    task automatic send_pair(input int sel, input logic [17:0] a, input logic [17:0] b,
                             output int t_fire, output bit ok);
        ok = 1'b0;
        t_fire = -1;
        in_valid[sel] = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready[sel]) begin
                t_fire = cyc;
                ok = 1'b1;
            end
            @(posedge CLK); #1;
            if (ok) break;
        end
        in_valid[sel] = 1'b0;
        in_a = 18'd0;
        in_b = 18'd0;
    endtask

    task automatic run_vec(input int sel, input int n, input int gap,
                           output int t_last, output bit ok);
        int t;
        bit f;
        ok = 1'b1;
        t_last = -1;
        for (int k = 0; k < n; k++) begin
            send_pair(sel, va[k], vb[k], t, f);
            if (!f) ok = 1'b0;
            t_last = t;
            if (k < n - 1) repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic wait_res(input int sel, output int t_v, output bit ok);
        ok = 1'b0;
        t_v = -1;
        for (int i = 0; i < 40; i++) begin
            if (res_valid[sel]) begin
                t_v = cyc;
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle(2);
        n_vec++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready[0]); end
        n_vec++; if (res_valid[0] !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid[0]); end
        n_vec++; if (res_data[0] !== 48'd0) begin n_err++; $display("FAIL reset_res_data: got %0d want 0", res_data[0]); end
        n_vec++; if (dsp_rst[0] !== 1'b1) begin n_err++; $display("FAIL reset_dsp_rst: got %b want 1", dsp_rst[0]); end
        n_vec++; if (dsp_ce[0] !== 1'b0) begin n_err++; $display("FAIL reset_dsp_ce: got %b want 0", dsp_ce[0]); end
        n_vec++; if (dsp_opmode[0] !== 8'h08) begin n_err++; $display("FAIL reset_opmode: got %h want 08", dsp_opmode[0]); end
`ifdef DSP_MAC_SEQ_PERF_CNT_EN
        n_vec++; if (perf_vec_cnt[0] !== 32'd0) begin n_err++; $display("FAIL reset_perf_vec: got %0d want 0", perf_vec_cnt[0]); end
        n_vec++; if (perf_stall_cnt[0] !== 32'd0) begin n_err++; $display("FAIL reset_perf_stall: got %0d want 0", perf_stall_cnt[0]); end
`endif
        RST = 1'b0;
        idle(1);
        n_vec++; if (dsp_ce[0] !== 1'b1) begin n_err++; $display("FAIL run_dsp_ce: got %b want 1", dsp_ce[0]); end
        n_vec++; if (dsp_a[0] !== 18'd0) begin n_err++; $display("FAIL idle_dsp_a: got %0d want 0", dsp_a[0]); end
    endtask

    task automatic test_back_to_back;
        int tl, tv;
        bit ok;
        va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
        vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
        // Combinational A/B on an accepted pair
        in_valid[0] = 1'b1; in_a = 18'd1; in_b = 18'd5; #1;
        n_vec++; if (dsp_a[0] !== 18'd1 || dsp_b[0] !== 18'd5) begin n_err++; $display("FAIL fire_dsp_ab: got %0d/%0d want 1/5", dsp_a[0], dsp_b[0]); end
        in_valid[0] = 1'b0; in_a = 18'd0; in_b = 18'd0; #1;
        run_vec(0, 4, 0, tl, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_accept: got timeout want accepted"); end
        n_vec++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_low: got %b want 0", in_ready[0]); end
        wait_res(0, tv, ok);
        n_vec++; if (!ok || tv != tl + 4) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", tv - tl, 4); end
        n_vec++; if (res_data[0] !== 48'd70) begin n_err++; $display("FAIL b2b_sum: got %0d want 70", res_data[0]); end
        res_ready = 1'b1; idle(1); res_ready = 1'b0;
        n_vec++; if (res_valid[0] !== 1'b0) begin n_err++; $display("FAIL b2b_valid_drop: got %b want 0", res_valid[0]); end
    endtask

    task automatic test_gaps;
        int t, tl, tv;
        bit ok;
        logic [7:0] exp_op;
        for (int k = 0; k < 4; k++) begin
            send_pair(0, 18'(k + 1), 18'(k + 5), t, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL gap_accept_%0d: got timeout want accepted", k); end
            exp_op = (k == 0) ? 8'h01 : 8'h09;
            n_vec++; if (dsp_opmode[0] !== exp_op) begin n_err++; $display("FAIL gap_opmode_%0d: got %h want %h", k, dsp_opmode[0], exp_op); end
            if (k < 3) begin
                idle(1);
                n_vec++; if (dsp_opmode[0] !== 8'h08) begin n_err++; $display("FAIL gap_bubble_%0d: got %h want 08", k, dsp_opmode[0]); end
                idle(1);
            end
        end
        wait_res(0, tv, ok);
        n_vec++; if (!ok || res_data[0] !== 48'd70) begin n_err++; $display("FAIL gap_sum: got %0d want 70", res_data[0]); end
        res_ready = 1'b1; idle(1); res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin va[k] = 18'd10; vb[k] = 18'd10; end
        run_vec(0, 4, 0, tl, ok);
        wait_res(0, tv, ok);
        n_vec++; if (!ok || res_data[0] !== 48'd400) begin n_err++; $display("FAIL second_vec_sum: got %0d want 400", res_data[0]); end
        res_ready = 1'b1; idle(1); res_ready = 1'b0;
    endtask

    task automatic test_saturate;
        int tl, tv;
        bit ok;
        for (int k = 0; k < 8; k++) begin va[k] = 18'h3FFFF; vb[k] = 18'h3FFFF; end
        run_vec(1, 8, 0, tl, ok);
        wait_res(1, tv, ok);
        n_vec++; if (!ok || tv != tl + 4) begin n_err++; $display("FAIL max_latency: got %0d want 4", tv - tl); end
        n_vec++; if (res_data[1] !== 48'd549751619592) begin n_err++; $display("FAIL max_sum: got %0d want 549751619592", res_data[1]); end
        res_ready = 1'b1; idle(1); res_ready = 1'b0;
    endtask

    task automatic test_hold_stall;
        int tl, tv;
        bit ok;
        RST = 1'b1; idle(1); RST = 1'b0; idle(2);
        va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
        vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
        run_vec(0, 4, 0, tl, ok);
        wait_res(0, tv, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL hold_reach: got timeout want res_valid"); end
        in_valid[0] = 1'b1; in_a = 18'd9; in_b = 18'd9;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if (res_valid[0] !== 1'b1 || res_data[0] !== 48'd70 || in_ready[0] !== 1'b0) begin
                n_err++; $display("FAIL hold_%0d: got v=%b d=%0d r=%b want v=1 d=70 r=0", i, res_valid[0], res_data[0], in_ready[0]);
            end
            idle(1);
        end
        in_valid[0] = 1'b0; in_a = 18'd0; in_b = 18'd0;
`ifdef DSP_MAC_SEQ_PERF_CNT_EN
        n_vec++; if (perf_stall_cnt[0] !== 32'd10) begin n_err++; $display("FAIL stall_cnt: got %0d want 10", perf_stall_cnt[0]); end
`endif
        res_ready = 1'b1; #1;
        n_vec++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL hs_in_ready_h0: got %b want 0", in_ready[0]); end
        idle(1); res_ready = 1'b0;
        n_vec++; if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin n_err++; $display("FAIL hs_h1: got v=%b r=%b want v=0 r=0", res_valid[0], in_ready[0]); end
        idle(1);
        n_vec++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL hs_in_ready_h2: got %b want 1", in_ready[0]); end
`ifdef DSP_MAC_SEQ_PERF_CNT_EN
        n_vec++; if (perf_vec_cnt[0] !== 32'd1) begin n_err++; $display("FAIL vec_cnt: got %0d want 1", perf_vec_cnt[0]); end
`endif
    endtask

    task automatic test_reset_mid;
        int t, tl, tv;
        bit ok;
        send_pair(0, 18'd7, 18'd7, t, ok);
        send_pair(0, 18'd9, 18'd9, t, ok);
        RST = 1'b1; #1;
        n_vec++; if (res_valid[0] !== 1'b0 || dsp_rst[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
            n_err++; $display("FAIL midrst: got v=%b rst=%b r=%b want 0/1/0", res_valid[0], dsp_rst[0], in_ready[0]);
        end
        idle(1); RST = 1'b0;
        for (int k = 0; k < 4; k++) begin va[k] = 18'd1; vb[k] = 18'd1; end
        run_vec(0, 4, 0, tl, ok);
        wait_res(0, tv, ok);
        n_vec++; if (!ok || tv != tl + 4 || res_data[0] !== 48'd4) begin n_err++; $display("FAIL midrst_sum: got %0d lat %0d want 4 lat 4", res_data[0], tv - tl); end
        // Reset while holding a result discards it
        RST = 1'b1; idle(1); RST = 1'b0;
        n_vec++; if (res_valid[0] !== 1'b0 || res_data[0] !== 48'd0) begin n_err++; $display("FAIL holdrst: got v=%b d=%0d want 0/0", res_valid[0], res_data[0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        in_valid = 2'b00;
        in_a = 18'd0;
        in_b = 18'd0;
        res_ready = 1'b0;
        test_reset;
        test_back_to_back;
        test_gaps;
        test_saturate;
        test_hold_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
